// File: rtl/byte_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// byte_ram_port_arbiter
//
// Shares port 1 of a byte-wide dual-port RAM between two requesters
// (A = CPU load/store unit, B = program loader/debug). Each accepted byte,
// halfword or word access is serialised into one RAM byte access per cycle,
// least significant byte first, and finished with a single response pulse
// to the requester that owns it.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   a_valid/a_ready           requester A handshake (ready is combinational)
//   a_addr/a_we/a_size/a_wdata requester A request payload
//   a_resp_valid/a_rdata      requester A one-cycle completion + load data
//   b_*                       identical set for requester B
//   ram_addr/ram_wdata/ram_wenable  RAM port-1 drive
//   ram_rdata                 RAM port-1 read byte (combinational from ram_addr)
// ---------------------------------------------------------------------------
module byte_ram_port_arbiter #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic                  a_we,
    input  logic [1:0]            a_size,
    input  logic [31:0]           a_wdata,
    output logic                  a_resp_valid,
    output logic [31:0]           a_rdata,

    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic                  b_we,
    input  logic [1:0]            b_size,
    input  logic [31:0]           b_wdata,
    output logic                  b_resp_valid,
    output logic [31:0]           b_rdata,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_wdata,
    output logic                  ram_wenable,
    input  logic [7:0]            ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_owner_b;       // 1 = current access belongs to B
    logic                  r_last_grant_b;  // 1 = B was granted most recently
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [31:0]           r_wdata;
    logic [1:0]            r_last_idx;      // N-1 for the access in flight
    logic [1:0]            r_idx;
    logic [31:0]           r_acc;
    logic                  r_a_resp_valid;
    logic [31:0]           r_a_rdata;
    logic                  r_b_resp_valid;
    logic [31:0]           r_b_rdata;

    logic                  w_idle;
    logic                  w_access;
    logic                  w_grant_a;
    logic                  w_grant_b;
    logic [1:0]            w_req_size;
    logic [1:0]            w_req_last_idx;
    logic [7:0]            w_wbyte;
    logic [31:0]           w_acc_next;
    logic [31:0]           w_mask;
    logic [31:0]           w_resp_data;

    assign w_idle   = (r_state == S_IDLE);
    assign w_access = (r_state == S_ACCESS);

    // Round-robin only matters on a tie: the side that did not win last time
    // takes it. A lone requester is always granted.
    assign w_grant_a = a_valid & (~b_valid | r_last_grant_b);
    assign w_grant_b = b_valid & (~a_valid | ~r_last_grant_b);

    // Reset masks the handshake combinationally so nothing is accepted in the
    // reset cycle even though the state register has not yet been cleared.
    assign a_ready = w_idle & w_grant_a & ~rst;
    assign b_ready = w_idle & w_grant_b & ~rst;

    assign w_req_size     = b_ready ? b_size : a_size;
    assign w_req_last_idx = (w_req_size == 2'd0) ? 2'd0 :
                            (w_req_size == 2'd1) ? 2'd1 : 2'd3;

    // RAM drive: address wraps naturally through the ADDR_WIDTH-bit add.
    assign w_wbyte     = r_wdata[{r_idx, 3'b000} +: 8];
    assign ram_addr    = w_access ? (r_addr + ADDR_WIDTH'(r_idx)) : '0;
    assign ram_wdata   = (w_access & r_we) ? w_wbyte : 8'h00;
    // Forced low during reset so an abandoned store cannot write a partial
    // byte in the cycle where reset is asserted.
    assign ram_wenable = w_access & r_we & ~rst;

    // Accumulator with the current read byte merged in at position idx.
    // NOTE: every always_comb output gets a default first so no latch is
    // inferred; the indexed update then only overrides one byte.
    always_comb begin
        w_acc_next                      = r_acc;
        w_acc_next[{r_idx, 3'b000} +: 8] = ram_rdata;
    end

    assign w_mask = (r_last_idx == 2'd0) ? 32'h0000_00FF :
                    (r_last_idx == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;

    assign w_resp_data = r_we ? 32'h0 : (w_acc_next & w_mask);

    // NOTE: all state in this block is updated with non-blocking assignments
    // so every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_owner_b      <= 1'b0;
            r_last_grant_b <= 1'b1;
            r_addr         <= '0;
            r_we           <= 1'b0;
            r_wdata        <= 32'h0;
            r_last_idx     <= 2'd0;
            r_idx          <= 2'd0;
            r_acc          <= 32'h0;
            r_a_resp_valid <= 1'b0;
            r_a_rdata      <= 32'h0;
            r_b_resp_valid <= 1'b0;
            r_b_rdata      <= 32'h0;
        end else begin
            // Responses are single-cycle; they are only raised on the last
            // ACCESS edge and fall back to zero everywhere else.
            r_a_resp_valid <= 1'b0;
            r_a_rdata      <= 32'h0;
            r_b_resp_valid <= 1'b0;
            r_b_rdata      <= 32'h0;

            case (r_state)
                S_IDLE: begin
                    if (a_ready || b_ready) begin
                        r_owner_b      <= b_ready;
                        r_last_grant_b <= b_ready;
                        r_addr         <= b_ready ? b_addr  : a_addr;
                        r_we           <= b_ready ? b_we    : a_we;
                        r_wdata        <= b_ready ? b_wdata : a_wdata;
                        r_last_idx     <= w_req_last_idx;
                        r_idx          <= 2'd0;
                        r_acc          <= 32'h0;
                        r_state        <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    if (!r_we) begin
                        r_acc <= w_acc_next;
                    end
                    if (r_idx == r_last_idx) begin
                        r_state <= S_DONE;
                        if (r_owner_b) begin
                            r_b_resp_valid <= 1'b1;
                            r_b_rdata      <= w_resp_data;
                        end else begin
                            r_a_resp_valid <= 1'b1;
                            r_a_rdata      <= w_resp_data;
                        end
                    end else begin
                        r_idx <= r_idx + 2'd1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign a_resp_valid = r_a_resp_valid;
    assign a_rdata      = r_a_rdata;
    assign b_resp_valid = r_b_resp_valid;
    assign b_rdata      = r_b_rdata;

endmodule

// File: tb/tb_byte_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_byte_ram_port_arbiter
//
// Directed bench for byte_ram_port_arbiter. A behavioural 4 KiB byte RAM is
// attached to port 1; a negedge monitor logs grants, RAM writes and
// responses with their cycle numbers, and each directed step compares those
// logs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_byte_ram_port_arbiter;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, a_we, a_resp_valid, a_ready;
    logic [AW-1:0] a_addr;
    logic [1:0]    a_size;
    logic [31:0]   a_wdata, a_rdata;
    logic          b_valid, b_we, b_resp_valid, b_ready;
    logic [AW-1:0] b_addr;
    logic [1:0]    b_size;
    logic [31:0]   b_wdata, b_rdata;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata, ram_rdata;
    logic          ram_wenable;

    always #5 clk = ~clk;

    byte_ram_port_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_addr       (a_addr),
        .a_we         (a_we),
        .a_size       (a_size),
        .a_wdata      (a_wdata),
        .a_resp_valid (a_resp_valid),
        .a_rdata      (a_rdata),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_addr       (b_addr),
        .b_we         (b_we),
        .b_size       (b_size),
        .b_wdata      (b_wdata),
        .b_resp_valid (b_resp_valid),
        .b_rdata      (b_rdata),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_wenable  (ram_wenable),
        .ram_rdata    (ram_rdata)
    );

    // Behavioural RAM: power-up pattern is addr[7:0] ^ 0x5A.
    logic [7:0] mem [0:4095];

    function automatic logic [7:0] init_byte(input int addr);
        logic [7:0] lo;
        lo = 8'(addr);
        return lo ^ 8'h5A;
    endfunction

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = init_byte(i);
    end

    always @(posedge clk) begin
        if (ram_wenable === 1'b1) mem[ram_addr] <= ram_wdata;
    end

    assign ram_rdata = mem[ram_addr];

    // Cycle counter and negedge monitor.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          grant_cyc[$];
    bit          grant_b[$];
    int          wr_addr[$];
    int          wr_data[$];
    int          a_resp_cyc[$];
    logic [31:0] a_resp_data[$];
    int          b_resp_cyc[$];
    logic [31:0] b_resp_data[$];
    int          watch_addr = -1;
    int          watch_hits = 0;
    int          overlap    = 0;
    int          leak       = 0;

    always @(negedge clk) begin
        if (a_ready === 1'b1) begin grant_cyc.push_back(cyc); grant_b.push_back(1'b0); end
        if (b_ready === 1'b1) begin grant_cyc.push_back(cyc); grant_b.push_back(1'b1); end
        if (ram_wenable === 1'b1) begin
            wr_addr.push_back(int'(ram_addr));
            wr_data.push_back(int'(ram_wdata));
        end
        if (a_resp_valid === 1'b1) begin a_resp_cyc.push_back(cyc); a_resp_data.push_back(a_rdata); end
        if (b_resp_valid === 1'b1) begin b_resp_cyc.push_back(cyc); b_resp_data.push_back(b_rdata); end
        if (int'(ram_addr) == watch_addr) watch_hits++;
        if (a_resp_valid === 1'b1 && b_resp_valid === 1'b1) overlap++;
        if ((a_resp_valid === 1'b1 && b_rdata !== 32'h0) ||
            (b_resp_valid === 1'b1 && a_rdata !== 32'h0)) leak++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        grant_cyc.delete();   grant_b.delete();
        wr_addr.delete();     wr_data.delete();
        a_resp_cyc.delete();  a_resp_data.delete();
        b_resp_cyc.delete();  b_resp_data.delete();
    endtask

    // Present one request, wait (bounded) for ready, then drop valid right
    // after the handshake edge. Returns in the first ACCESS cycle.
    task automatic issue(input bit to_b, input int addr, input bit we,
                         input int size, input logic [31:0] wdata);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        if (to_b) begin
            b_valid = 1'b1; b_addr = AW'(addr); b_we = we; b_size = 2'(size); b_wdata = wdata;
        end else begin
            a_valid = 1'b1; a_addr = AW'(addr); a_we = we; a_size = 2'(size); a_wdata = wdata;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = to_b ? (b_ready === 1'b1) : (a_ready === 1'b1);
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("handshake_seen", 32'(got), 32'd1);
    endtask

    function automatic int wa(input int i);
        return (i < wr_addr.size()) ? wr_addr[i] : -1;
    endfunction

    function automatic int wd(input int i);
        return (i < wr_data.size()) ? wr_data[i] : -1;
    endfunction

    function automatic logic [31:0] ard(input int i);
        return (i < a_resp_data.size()) ? a_resp_data[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] brd(input int i);
        return (i < b_resp_data.size()) ? b_resp_data[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int a_lat(input int g);
        return (a_resp_cyc.size() > 0 && grant_cyc.size() > g) ? a_resp_cyc[0] - grant_cyc[g] : -1;
    endfunction

    function automatic int b_lat(input int g);
        return (b_resp_cyc.size() > 0 && grant_cyc.size() > g) ? b_resp_cyc[0] - grant_cyc[g] : -1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_addr = '0; a_we = 1'b0; a_size = 2'd0; a_wdata = 32'h0;
        b_valid = 1'b0; b_addr = '0; b_we = 1'b0; b_size = 2'd0; b_wdata = 32'h0;

        // ---- Reset: ready masked while rst is high, outputs idle afterwards
        repeat (2) @(posedge clk);
        #1;
        a_valid = 1'b1; b_valid = 1'b1;
        @(negedge clk);
        check("rst_a_ready",  32'(a_ready),     32'd0);
        check("rst_b_ready",  32'(b_ready),     32'd0);
        check("rst_wenable",  32'(ram_wenable), 32'd0);
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("rst_a_resp",   32'(a_resp_valid), 32'd0);
        check("rst_b_resp",   32'(b_resp_valid), 32'd0);
        check("rst_a_rdata",  a_rdata,           32'h0);
        check("rst_b_rdata",  b_rdata,           32'h0);
        check("rst_ram_addr", 32'(ram_addr),     32'h0);
        check("rst_ram_wdata",32'(ram_wdata),    32'h0);
        clear_logs();

        // ---- Test 1: A stores word 0xDDCCBBAA at 0x010
        issue(1'b0, 'h010, 1'b1, 2, 32'hDDCC_BBAA);
        repeat (8) @(posedge clk);
        check("t1_grants",   32'(grant_cyc.size()), 32'd1);
        check("t1_nwrites",  32'(wr_addr.size()),   32'd4);
        check("t1_wa0", 32'(wa(0)), 32'h010);  check("t1_wd0", 32'(wd(0)), 32'hAA);
        check("t1_wa1", 32'(wa(1)), 32'h011);  check("t1_wd1", 32'(wd(1)), 32'hBB);
        check("t1_wa2", 32'(wa(2)), 32'h012);  check("t1_wd2", 32'(wd(2)), 32'hCC);
        check("t1_wa3", 32'(wa(3)), 32'h013);  check("t1_wd3", 32'(wd(3)), 32'hDD);
        check("t1_a_nresp",  32'(a_resp_cyc.size()), 32'd1);
        check("t1_latency",  32'(a_lat(0)),           32'd5);
        check("t1_store_rdata", ard(0),               32'h0);
        check("t1_b_nresp",  32'(b_resp_cyc.size()), 32'd0);
        clear_logs();

        // ---- Test 2: A loads half at 0x011, then byte at 0x013
        issue(1'b0, 'h011, 1'b0, 1, 32'h0);
        repeat (6) @(posedge clk);
        check("t2_half_data", ard(0),          32'h0000_CCBB);
        check("t2_half_lat",  32'(a_lat(0)),   32'd3);
        check("t2_nwrites",   32'(wr_addr.size()), 32'd0);
        clear_logs();
        issue(1'b0, 'h013, 1'b0, 0, 32'h0);
        repeat (6) @(posedge clk);
        check("t2_byte_data", ard(0),          32'h0000_00DD);
        check("t2_byte_lat",  32'(a_lat(0)),   32'd2);
        clear_logs();

        // ---- Test 3: B word store/load wrapping past the top of the RAM
        issue(1'b1, 'hFFE, 1'b1, 3, 32'h4433_2211);
        repeat (8) @(posedge clk);
        check("t3_nwrites", 32'(wr_addr.size()), 32'd4);
        check("t3_wa0", 32'(wa(0)), 32'hFFE);  check("t3_wd0", 32'(wd(0)), 32'h11);
        check("t3_wa1", 32'(wa(1)), 32'hFFF);  check("t3_wd1", 32'(wd(1)), 32'h22);
        check("t3_wa2", 32'(wa(2)), 32'h000);  check("t3_wd2", 32'(wd(2)), 32'h33);
        check("t3_wa3", 32'(wa(3)), 32'h001);  check("t3_wd3", 32'(wd(3)), 32'h44);
        check("t3_store_lat", 32'(b_lat(0)), 32'd5);
        clear_logs();
        issue(1'b1, 'hFFE, 1'b0, 2, 32'h0);
        repeat (8) @(posedge clk);
        check("t3_load_data", brd(0),                32'h4433_2211);
        check("t3_a_nresp",   32'(a_resp_cyc.size()), 32'd0);
        clear_logs();

        // ---- Test 4: continuous contention with byte loads
        @(posedge clk); #1;
        a_valid = 1'b1; a_addr = 'h010; a_we = 1'b0; a_size = 2'd0;
        b_valid = 1'b1; b_addr = 'h011; b_we = 1'b0; b_size = 2'd0;
        for (int i = 0; i < 40 && grant_cyc.size() < 4; i++) @(negedge clk);
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (6) @(posedge clk);
        check("t4_ngrants", 32'(grant_cyc.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_owner%0d", i),
                  (i < grant_b.size()) ? 32'(grant_b[i]) : 32'hFFFF_FFFF, 32'(i % 2));
        end
        for (int i = 1; i < 4; i++) begin
            check($sformatf("t4_gap%0d", i),
                  (i < grant_cyc.size()) ? 32'(grant_cyc[i] - grant_cyc[i-1]) : 32'hFFFF_FFFF, 32'd3);
        end
        check("t4_a_nresp", 32'(a_resp_cyc.size()), 32'd2);
        check("t4_b_nresp", 32'(b_resp_cyc.size()), 32'd2);
        check("t4_a_data0", ard(0), 32'h0000_00AA);
        check("t4_b_data0", brd(0), 32'h0000_00BB);
        check("t4_a_data1", ard(1), 32'h0000_00AA);
        check("t4_b_data1", brd(1), 32'h0000_00BB);
        check("t4_a_resp_at_a_grant",
              (a_resp_cyc.size() > 1 && grant_cyc.size() > 2) ? 32'(a_resp_cyc[1] - grant_cyc[2]) : 32'hFFFF_FFFF,
              32'd2);
        check("t4_b_resp_at_b_grant",
              (b_resp_cyc.size() > 1 && grant_cyc.size() > 3) ? 32'(b_resp_cyc[1] - grant_cyc[3]) : 32'hFFFF_FFFF,
              32'd2);
        clear_logs();

        // ---- Test 5: reset in the 2nd ACCESS cycle of a word store at 0x020
        issue(1'b0, 'h020, 1'b1, 2, 32'h8765_4321);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("t5_wen_in_reset", 32'(ram_wenable), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        check("t5_nwrites", 32'(wr_addr.size()), 32'd1);
        check("t5_wa0",     32'(wa(0)),          32'h020);
        check("t5_wd0",     32'(wd(0)),          32'h21);
        check("t5_mem20",   32'(mem['h020]),     32'h21);
        check("t5_mem21",   32'(mem['h021]),     32'(init_byte('h021)));
        check("t5_mem22",   32'(mem['h022]),     32'(init_byte('h022)));
        check("t5_mem23",   32'(mem['h023]),     32'(init_byte('h023)));
        check("t5_no_resp", 32'(a_resp_cyc.size() + b_resp_cyc.size()), 32'd0);
        clear_logs();
        @(posedge clk); #1;
        a_valid = 1'b1; a_addr = 'h030; a_we = 1'b0; a_size = 2'd0;
        b_valid = 1'b1; b_addr = 'h031; b_we = 1'b0; b_size = 2'd0;
        for (int i = 0; i < 20 && grant_cyc.size() < 1; i++) @(negedge clk);
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (6) @(posedge clk);
        check("t5_tie_owner", (grant_b.size() > 0) ? 32'(grant_b[0]) : 32'hFFFF_FFFF, 32'd0);
        check("t5_tie_data",  ard(0), 32'(init_byte('h030)));
        clear_logs();

        // ---- Test 6: A raises then drops valid while B is busy
        watch_addr = 'h0A5;
        watch_hits = 0;
        issue(1'b1, 'h010, 1'b0, 2, 32'h0);
        @(posedge clk); #1;
        a_valid = 1'b1; a_addr = 'h0A5; a_we = 1'b1; a_size = 2'd0; a_wdata = 32'h0000_00EE;
        repeat (2) @(posedge clk);
        #1;
        a_valid = 1'b0;
        repeat (10) @(posedge clk);
        check("t6_ngrants",   32'(grant_cyc.size()),  32'd1);
        check("t6_a_nresp",   32'(a_resp_cyc.size()), 32'd0);
        check("t6_watch",     32'(watch_hits),        32'd0);
        check("t6_memA5",     32'(mem['h0A5]),        32'(init_byte('h0A5)));
        check("t6_b_data",    brd(0),                 32'hDDCC_BBAA);
        watch_addr = -1;

        // ---- Whole-run response hygiene
        check("resp_overlap", 32'(overlap), 32'd0);
        check("rdata_leak",   32'(leak),    32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
